// File: rtl/dshot_pkg.sv
// Shared DShot definitions: FSM states, timing helpers and the frame CRC.
package dshot_pkg;

  typedef enum logic [1:0] {StIdle, StBit, StGap} state_e;

  localparam int unsigned FrameBits = 16;

  function automatic int unsigned calc_bit_ticks(input int unsigned base_freq,
                                                 input int unsigned rate);
    return base_freq / rate;
  endfunction

  function automatic int unsigned calc_t1h(input int unsigned bit_ticks);
    return bit_ticks * 3 / 4;
  endfunction

  function automatic int unsigned calc_t0h(input int unsigned bit_ticks);
    return bit_ticks * 3 / 8;
  endfunction

  function automatic int unsigned calc_gap_ticks(input int unsigned gap_bits,
                                                 input int unsigned bit_ticks);
    return gap_bits * bit_ticks;
  endfunction

  // XOR of the three nibbles of {throttle, telemetry}.
  function automatic logic [3:0] dshot_crc(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

endpackage

// File: rtl/dshot_tx.sv
// Single-channel DShot serializer: accepts a throttle word via VALID/READY and
// emits a 16-bit pulse-width-coded frame followed by a mandatory low gap.
module dshot_tx
  import dshot_pkg::*;
#(
  parameter int unsigned BASE_FREQ  = 16_000_000,
  parameter int unsigned DSHOT_RATE = 600_000,
  parameter int unsigned GAP_BITS   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] THROTTLE,
  input  logic        TELEM_REQ,
  input  logic        VALID,
  output logic        READY,
  output logic        DSHOT_OUT
);

  localparam int unsigned BitTicks = calc_bit_ticks(BASE_FREQ, DSHOT_RATE);
  localparam int unsigned T1h      = calc_t1h(BitTicks);
  localparam int unsigned T0h      = calc_t0h(BitTicks);
  localparam int unsigned GapTicks = calc_gap_ticks(GAP_BITS, BitTicks);
  localparam int unsigned MaxTicks = (BitTicks > GapTicks) ? BitTicks : GapTicks;
  localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  localparam logic [TickW-1:0] BitLast  = TickW'(BitTicks - 1);
  localparam logic [TickW-1:0] GapLast  = TickW'(GapTicks - 1);
  localparam logic [TickW-1:0] T1hTicks = TickW'(T1h);
  localparam logic [TickW-1:0] T0hTicks = TickW'(T0h);

  state_e                 state_q, state_d;
  logic [TickW-1:0]       tick_q, tick_d;
  logic [3:0]             idx_q, idx_d;
  logic [FrameBits-1:0]   shift_q, shift_d;
  logic                   ready_q, ready_d;
  logic                   out_q, out_d;
  logic [TickW-1:0]       high_d;
  logic                   accept;

  assign accept    = VALID & ready_q;
  assign READY     = ready_q;
  assign DSHOT_OUT = out_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StBit: begin
        if (tick_q == BitLast) begin
          tick_d  = '0;
          shift_d = {shift_q[FrameBits-2:0], 1'b0};
          if (idx_q == 4'd0) begin
            state_d = StGap;
          end else begin
            idx_d = idx_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StGap: begin
        if (tick_q == GapLast) begin
          state_d = StIdle;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // READY is only high in IDLE or the final gap tick, so this covers back-to-back frames.
    if (accept) begin
      state_d = StBit;
      tick_d  = '0;
      idx_d   = 4'd15;
      shift_d = {THROTTLE, TELEM_REQ, dshot_crc({THROTTLE, TELEM_REQ})};
    end

    // Outputs are registered from the next state so the first pulse starts at the accept edge.
    ready_d = (state_d == StIdle) || ((state_d == StGap) && (tick_d == GapLast));
    high_d  = shift_d[FrameBits-1] ? T1hTicks : T0hTicks;
    out_d   = (state_d == StBit) && (tick_d < high_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      tick_q  <= '0;
      idx_q   <= 4'd0;
      shift_q <= '0;
      ready_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_dshot_tx.sv
// Self-checking bench for dshot_tx: directed frames, busy/hold behaviour, resets and
// randomized throttle words compared against a cycle-by-cycle waveform model.
module tb_dshot_tx;

  localparam int unsigned BaseFreq = 16_000_000;
  localparam int unsigned Rate     = 600_000;
  localparam int unsigned GapBits  = 2;
  localparam int BT     = BaseFreq / Rate;
  localparam int HI1    = BT * 3 / 4;
  localparam int HI0    = BT * 3 / 8;
  localparam int GAP    = GapBits * BT;
  localparam int PERIOD = 16 * BT + GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        tel = 1'b0;
  logic [10:0] thr = '0;
  logic        ready;
  logic        dout;

  int tests = 0;
  int fails = 0;
  bit obs_out[PERIOD];
  bit obs_rdy[PERIOD];

  always #5 clk = ~clk;

  dshot_tx #(
    .BASE_FREQ (BaseFreq),
    .DSHOT_RATE(Rate),
    .GAP_BITS  (GapBits)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .THROTTLE (thr),
    .TELEM_REQ(tel),
    .VALID    (valid),
    .READY    (ready),
    .DSHOT_OUT(dout)
  );

  function automatic logic [15:0] model_frame(input logic [10:0] t, input logic r);
    logic [11:0] v;
    logic [11:0] c;
    v = {t, r};
    c = (v ^ (v >> 4) ^ (v >> 8)) & 12'hF;
    return {v, c[3:0]};
  endfunction

  // Expected line level k cycles after the accept edge.
  function automatic bit model_out(input logic [15:0] f, input int k);
    int b;
    int hi;
    if (k >= 16 * BT) return 1'b0;
    b  = 15 - k / BT;
    hi = f[b] ? HI1 : HI0;
    return (k % BT) < hi;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call just after an accept edge; records one full frame+gap and checks it.
  task automatic capture(input logic [15:0] f, input string tag, input bit inject);
    logic [63:0] o;
    logic [63:0] e;
    int gap_hi;
    int first;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      obs_out[k] = dout;
      obs_rdy[k] = ready;
      if (inject && k == 100) begin
        thr   = 11'd500;
        tel   = 1'b0;
        valid = 1'b1;
      end
    end
    for (int b = 0; b < 16; b++) begin
      o = '0;
      e = '0;
      for (int t = 0; t < BT; t++) begin
        o[t] = obs_out[b * BT + t];
        e[t] = model_out(f, b * BT + t);
      end
      check($sformatf("%s bit%0d", tag, 15 - b), o, e);
    end
    gap_hi = 0;
    for (int k = 16 * BT; k < PERIOD; k++) if (obs_out[k]) gap_hi++;
    check($sformatf("%s gap highs", tag), 64'(gap_hi), 64'd0);
    first = -1;
    for (int k = 0; k < PERIOD; k++) if (obs_rdy[k] && first < 0) first = k;
    check($sformatf("%s ready return", tag), 64'(first), 64'(PERIOD - 1));
  endtask

  task automatic send(input logic [10:0] t, input logic r);
    int n;
    n = 0;
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready before send", 64'(ready), 64'd1);
    thr   = t;
    tel   = r;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    thr   = 11'($urandom);
    tel   = 1'($urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rt;
    logic        rr;
    int          hi;
    int          lo;
    int          mism;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ready", 64'(ready), 64'd0);
    check("reset dout", 64'(dout), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", 64'(ready), 64'd1);

    hi = 0;
    lo = 0;
    repeat (1000) begin
      @(negedge clk);
      if (dout) hi++;
      if (!ready) lo++;
    end
    check("idle dout highs", 64'(hi), 64'd0);
    check("idle ready lows", 64'(lo), 64'd0);

    send(11'd1046, 1'b0);
    capture(16'h82C6, "t1046", 1'b0);
    send(11'd48, 1'b1);
    capture(16'h0617, "t48", 1'b0);
    send(11'd2047, 1'b1);
    capture(16'hFFFF, "t2047", 1'b0);
    send(11'd0, 1'b0);
    capture(16'h0000, "t0", 1'b0);

    // Busy: a command presented mid-frame is ignored, then taken once READY returns.
    send(11'd1046, 1'b0);
    capture(16'h82C6, "busy", 1'b1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    capture(16'h3E85, "held500", 1'b0);

    repeat (4) begin
      rt = 11'($urandom_range(0, 2047));
      rr = 1'($urandom_range(0, 1));
      send(rt, rr);
      capture(model_frame(rt, rr), $sformatf("rand%0d", rt), 1'b0);
    end

    // Reset mid-frame.
    send(11'd1046, 1'b0);
    mism = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dout !== model_out(16'h82C6, k)) mism++;
    end
    check("partial frame mismatches", 64'(mism), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midreset dout", 64'(dout), 64'd0);
    check("midreset ready", 64'(ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midreset ready back", 64'(ready), 64'd1);
    hi = 0;
    repeat (600) begin
      @(negedge clk);
      if (dout) hi++;
    end
    check("after reset highs", 64'(hi), 64'd0);

    // VALID together with RST: nothing accepted.
    thr   = 11'd1046;
    rst   = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    check("rst+valid ready", 64'(ready), 64'd0);
    check("rst+valid dout", 64'(dout), 64'd0);
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("rst+valid ready back", 64'(ready), 64'd1);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (dout) hi++;
    end
    check("rst+valid highs", 64'(hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
